// File: rtl/main_memory_resp_pkg.sv
// Shared constants, FSM state encoding and request-kind encoding for the
// main-memory responder and the data cache that talks to it.
package mem_pkg;

    localparam int MEM_BYTES  = 1024;
    localparam int BLOCK_SIZE = 16;
    localparam int BEAT_BYTES = 8;
    localparam int OFFSET_W   = 4;
    localparam int INDEX_W    = 4;
    localparam int RANGE_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BEAT0 = 2'd2,
        BEAT1 = 2'd3
    } mem_state_e;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

endpackage

// File: rtl/main_memory_resp_if.sv
// Request/response channel between the data cache (master) and main memory (slave).
interface main_memory_resp_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_last;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_last, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_last, resp_error
    );

endinterface

// File: rtl/mem_byte_array.sv
// Byte-addressed storage: one 8-byte write port and one combinational 8-byte
// read port, both at arbitrary byte addresses (wrapping inside the array).
module mem_byte_array #(
    parameter int MEM_BYTES = 1024
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_BYTES)-1:0] waddr,
    input  logic [63:0]                  wdata,
    input  logic [$clog2(MEM_BYTES)-1:0] raddr,
    output logic [63:0]                  rdata
);

    localparam int ADDR_W = $clog2(MEM_BYTES);

    // Contents start at zero and are deliberately untouched by reset.
    logic [7:0] mem_reg [MEM_BYTES] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int j = 0; j < 8; j++) begin
                mem_reg[waddr + ADDR_W'(j)] <= wdata[j*8 +: 8];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rd
            wire [ADDR_W-1:0] byte_addr = raddr + ADDR_W'(gi);
            assign rdata[gi*8 +: 8] = mem_reg[byte_addr];
        end
    endgenerate

endmodule

// File: rtl/main_memory_resp.sv
// Main-memory responder: serves 16-byte block reads as two 64-bit beats and
// 8-byte writes with a single ack beat, after a fixed access latency.
module main_memory_resp #(
    parameter int MEM_BYTES  = mem_pkg::MEM_BYTES,
    parameter int BLOCK_SIZE = mem_pkg::BLOCK_SIZE,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              reset,
    main_memory_resp_if.slave bus
);

    import mem_pkg::*;

    localparam int ADDR_W = $clog2(MEM_BYTES);
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ready_reg;
    req_kind_e         kind_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [63:0]       wdata_reg;

    logic        accept;
    logic        resp_fire;
    logic        read_oor;
    logic        write_oor;
    logic        array_we;
    logic [ADDR_W-1:0] array_raddr;
    logic [63:0] array_rdata;

    assign accept    = bus.req_valid && ready_reg;
    assign resp_fire = bus.resp_valid && bus.resp_ready;

    // Write range check is done 65 bits wide so addresses near 2^64 cannot wrap in.
    assign read_oor  = (bus.req_addr >> ADDR_W) != 64'd0;
    assign write_oor = ({1'b0, bus.req_addr} + 65'd7) > 65'(MEM_BYTES - 1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_reg == '0) state_next = BEAT0;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            BEAT0: begin
                if (resp_fire) begin
                    state_next = (kind_reg == REQ_READ && !err_reg) ? BEAT1 : IDLE;
                end
            end
            BEAT1: begin
                if (resp_fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            kind_reg  <= REQ_READ;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= (state_next == IDLE);
            if (accept) begin
                kind_reg  <= req_kind_e'(bus.req_write);
                err_reg   <= bus.req_write ? write_oor : read_oor;
                addr_reg  <= bus.req_addr[ADDR_W-1:0];
                wdata_reg <= bus.req_wdata;
            end
        end
    end

    // The write lands on the same edge that moves WAIT into BEAT0.
    assign array_we = !reset && state_reg == WAIT && cnt_reg == '0
                      && kind_reg == REQ_WRITE && !err_reg;
    assign array_raddr = {addr_reg[ADDR_W-1:OFF_W], (state_reg == BEAT1), (OFF_W-1)'(0)};

    mem_byte_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .waddr (addr_reg),
        .wdata (wdata_reg),
        .raddr (array_raddr),
        .rdata (array_rdata)
    );

    assign bus.req_ready  = ready_reg;
    assign bus.resp_valid = (state_reg == BEAT0) || (state_reg == BEAT1);
    assign bus.resp_data  = (bus.resp_valid && kind_reg == REQ_READ && !err_reg)
                            ? array_rdata : 64'd0;
    assign bus.resp_last  = (state_reg == BEAT1)
                            || (state_reg == BEAT0 && (kind_reg == REQ_WRITE || err_reg));
    assign bus.resp_error = (state_reg == BEAT0) && err_reg;

endmodule
